// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared types and constants for the I2C bus arbiter and its round-robin picker.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package i2c_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_OWN_SEN  = 2'd1,
      ST_OWN_OLED = 2'd2,
      ST_GUARD    = 2'd3
   } arb_state_t;

   // Owner codes, bit-compatible with {gnt_oled, gnt_sen}
   localparam logic [1:0] OWNER_NONE = 2'b00;
   localparam logic [1:0] OWNER_SEN  = 2'b01;
   localparam logic [1:0] OWNER_OLED = 2'b10;

   // Requester indices into the eligible vector
   localparam int REQ_SEN  = 0;
   localparam int REQ_OLED = 1;

   // Defaults for a 125 MHz clk: 5 us bus-free time, 100 ms hold limit
   localparam int T_BUF_DEF    = 625;
   localparam int MAX_HOLD_DEF = 12_500_000;
   localparam int CNT_W_DEF    = 24;

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Request/grant handshake and pad signals between the two I2C masters, the pads and the arbiter.
// Latency: n/a (wiring only).
// Backpressure: n/a; requests are levels held until the owner's transaction ends.
interface i2c_bus_arbiter_if;

   logic       req_sen;
   logic       req_oled;
   logic       gnt_sen;
   logic       gnt_oled;
   logic       sda_o_sen;
   logic       sda_t_sen;
   logic       scl_t_sen;
   logic       sda_o_oled;
   logic       sda_t_oled;
   logic       scl_t_oled;
   logic       sda_i_sen;
   logic       sda_i_oled;
   logic       sda_i;
   logic       sda_o;
   logic       sda_t;
   logic       scl;
   logic [1:0] owner;
   logic       timeout;

   // Masters, sequencer and IOBUF side
   modport master (
      output req_sen, req_oled,
      output sda_o_sen, sda_t_sen, scl_t_sen,
      output sda_o_oled, sda_t_oled, scl_t_oled,
      output sda_i,
      input  gnt_sen, gnt_oled, sda_i_sen, sda_i_oled,
      input  sda_o, sda_t, scl, owner, timeout
   );

   // Arbiter side
   modport slave (
      input  req_sen, req_oled,
      input  sda_o_sen, sda_t_sen, scl_t_sen,
      input  sda_o_oled, sda_t_oled, scl_t_oled,
      input  sda_i,
      output gnt_sen, gnt_oled, sda_i_sen, sda_i_oled,
      output sda_o, sda_t, scl, owner, timeout
   );

endinterface

// File: rtl/i2c_bus_arbiter_rr2.sv
// Two-input round-robin pick: winner is the only eligible input, or the one that did not win last.
// Latency: combinational.
// Backpressure: none; caller decides when to act on the pick.
module arb_rr2 (
   input  logic [1:0] elig,
   input  logic       last,
   output logic       win_vld,
   output logic       win
);

   // Pick the sole eligible input, or alternate when both are eligible
   always_comb begin
      win_vld = |elig;
      win     = 1'b0;
      case (elig)
         2'b01:   win = 1'b0;
         2'b10:   win = 1'b1;
         2'b11:   win = ~last;
         default: win = 1'b0;
      endcase
   end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C bus between the sensor and OLED masters with round-robin grants, guard time and hold timeout.
// Latency: req->gnt 1 cycle from IDLE; grant-to-grant gap at least T_BUF+1 cycles.
// Backpressure: requests wait while another owner holds the bus or during the guard time.
module i2c_bus_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int T_BUF    = T_BUF_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input logic          clk,
   input logic          rst_n,
   i2c_bus_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(T_BUF - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MAX_HOLD - 1);

   arb_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             last_oled, last_oled_nxt;
   logic             blk_sen, blk_oled;
   logic             set_blk_sen, set_blk_oled;
   logic             timeout_q, timeout_nxt;
   logic [1:0]       elig;
   logic             win_vld, win;

   // A master that timed out stays ineligible until it drops its request
   always_comb begin
      elig           = 2'b00;
      elig[REQ_SEN]  = bus.req_sen  & ~blk_sen;
      elig[REQ_OLED] = bus.req_oled & ~blk_oled;
   end

   arb_rr2 u_rr (
      .elig    (elig),
      .last    (last_oled),
      .win_vld (win_vld),
      .win     (win)
   );

   // State, shared hold/guard counter, round-robin history and timeout pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         last_oled <= 1'b1;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         last_oled <= last_oled_nxt;
         timeout_q <= timeout_nxt;
      end
   end

   // Blocked flags set on timeout and cleared whenever the request is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_sen  <= 1'b0;
         blk_oled <= 1'b0;
      end else begin
         blk_sen  <= bus.req_sen  & (blk_sen  | set_blk_sen);
         blk_oled <= bus.req_oled & (blk_oled | set_blk_oled);
      end
   end

   // Next-state: grant from IDLE, release on req drop or hold limit, count out the guard
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      last_oled_nxt = last_oled;
      timeout_nxt   = 1'b0;
      set_blk_sen   = 1'b0;
      set_blk_oled  = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_nxt = '0;
            if (win_vld) begin
               state_nxt     = win ? ST_OWN_OLED : ST_OWN_SEN;
               last_oled_nxt = win;
            end
         end
         ST_OWN_SEN: begin
            if (!bus.req_sen) begin
               state_nxt = ST_GUARD;
               cnt_nxt   = '0;
            end else if (cnt == HOLD_LAST) begin
               state_nxt   = ST_GUARD;
               cnt_nxt     = '0;
               timeout_nxt = 1'b1;
               set_blk_sen = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_OWN_OLED: begin
            if (!bus.req_oled) begin
               state_nxt = ST_GUARD;
               cnt_nxt   = '0;
            end else if (cnt == HOLD_LAST) begin
               state_nxt    = ST_GUARD;
               cnt_nxt      = '0;
               timeout_nxt  = 1'b1;
               set_blk_oled = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_GUARD: begin
            if (cnt == GUARD_LAST) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Pad mux and SDA read-back: released/idle-high unless a master owns the bus
   always_comb begin
      bus.gnt_sen    = 1'b0;
      bus.gnt_oled   = 1'b0;
      bus.owner      = OWNER_NONE;
      bus.scl        = 1'b1;
      bus.sda_o      = 1'b1;
      bus.sda_t      = 1'b1;
      bus.sda_i_sen  = 1'b1;
      bus.sda_i_oled = 1'b1;
      case (state)
         ST_OWN_SEN: begin
            bus.gnt_sen   = 1'b1;
            bus.owner     = OWNER_SEN;
            bus.scl       = bus.scl_t_sen;
            bus.sda_o     = bus.sda_o_sen;
            bus.sda_t     = bus.sda_t_sen;
            bus.sda_i_sen = bus.sda_i;
         end
         ST_OWN_OLED: begin
            bus.gnt_oled   = 1'b1;
            bus.owner      = OWNER_OLED;
            bus.scl        = bus.scl_t_oled;
            bus.sda_o      = bus.sda_o_oled;
            bus.sda_t      = bus.sda_t_oled;
            bus.sda_i_oled = bus.sda_i;
         end
         default: ;
      endcase
   end

   assign bus.timeout = timeout_q;

endmodule
